mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Consumer side of the EXE→MEM pipeline register: takes the latched MEM-stage fields, runs the data-SRAM request/response handshake for loads and stores, and applies byte/halfword strobe generation, write-data replication, load extraction and sign/zero extension. It presents the finished result to the WB stage through a valid/allowin handshake. It back-pressures the EXE→MEM register through `in_ready` while a memory access is outstanding.

## Interface
- No parameters; address and data widths are fixed at 32 bits.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  MEM-stage fields below hold a live instruction.
- `in_ready`  out  1  stage accepts an instruction this cycle; drives EXE ready_go.
- `mem_pc`, `mem_alu_result`, `mem_dram_waddr`, `mem_dram_wdata`  in  32 each  PC, ALU result, memory address, store data.
- `mem_ref_we`  in  1  register-file write enable.
- `mem_rd`  in  5  destination register.
- `mem_dram_re`, `mem_dram_we`  in  1 each  load / store.
- `mem_rdram_num`, `mem_wdram_num`  in  2 each  access size: 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- `mem_rdram_need_signed_extend`, `mem_rdram_need_zero_extend`  in  1 each  load extension mode.
- `data_req`, `data_wr`  out  1 each  SRAM request, write flag.
- `data_wstrb`  out  4  byte write strobes.
- `data_addr`, `data_wdata`  out  32 each  request address, aligned store data.
- `data_addr_ok`, `data_data_ok`  in  1 each  request accepted, response complete.
- `data_rdata`  in  32  load response word.
- `wb_allowin`  in  1  WB stage can take a result.
- `wb_valid`, `wb_we`  out  1 each  result valid, register write enable.
- `wb_rd`  out  5  destination register.
- `wb_result`, `wb_pc`  out  32 each  write-back value, PC.

## Operation
- FSM states:
  - IDLE: no instruction held.
  - REQ: `data_req` asserted.
  - WAIT: awaiting `data_data_ok`.
  - DONE: result held for WB.
- `in_ready` = (state==IDLE) | (state==DONE & `wb_allowin`).
- Accept on `in_valid & in_ready`: latch all `mem_*` fields.
  - Next state is REQ if `dram_re | dram_we`, else DONE.
  - If both `re` and `we` are set, the access is a store.
- REQ: `data_req`=1, with `data_addr`, `data_wr`, `data_wstrb`, `data_wdata` stable from latched fields. On `data_addr_ok` go to WAIT.
- WAIT: on `data_data_ok` capture the load result (stores capture nothing), then go to DONE.
- DONE: `wb_valid`=1. On `wb_allowin`:
  - with a new accept → REQ/DONE per the new instruction;
  - otherwise → IDLE.
- `data_addr` = {waddr[31:2], 2'b00}.
- Store strobes:
  - byte: 4'b0001 << addr[1:0];
  - half: addr[1] ? 4'b1100 : 4'b0011;
  - word: 4'b1111.
- Store data:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: wdata.
- Load select:
  - byte = rdata >> (8·addr[1:0]), low 8 bits;
  - half = addr[1] ? rdata[31:16] : rdata[15:0];
  - word = rdata.
- Load extension:
  - signed flag set → sign-extend (takes precedence over the zero flag);
  - otherwise → zero-extend.
- Misalignment is not checked. Low address bits not used by the size are ignored.
- `wb_result` = extended load data for loads, `mem_alu_result` otherwise. `wb_we`/`wb_rd`/`wb_pc` come from the latched fields.

## Timing
- Reset (async assert, sync release):
  - state = IDLE;
  - all outputs 0, except `in_ready` = 1 combinationally (it decodes IDLE).
- Non-memory instruction: accept in cycle N, `wb_valid` in N+1. Sustained throughput is 1 per cycle while `wb_allowin`=1.
- Memory instruction:
  - `data_req` rises in N+1 and holds until the `data_addr_ok` cycle inclusive;
  - `wb_valid` is asserted the cycle after `data_data_ok`.
  - Minimum latency with `addr_ok` and `data_ok` each 1 cycle: `wb_valid` in N+3.
- Single outstanding request.
  - `data_data_ok` is sampled only in WAIT; it is ignored in IDLE/REQ/DONE, which discards stale responses after a reset.
  - `data_addr_ok` is ignored when `data_req`=0.
- WB outputs stay stable while `wb_valid`=1 and `wb_allowin`=0. `in_ready` stays 0 during REQ/WAIT.
- Reset mid-REQ/WAIT: `data_req` drops immediately and the instruction is lost.

## Test plan
- Reset: drive `rst`=0 mid-WAIT → `data_req`=0, `wb_valid`=0, `in_ready`=1 asynchronously. A later `data_data_ok` produces no `wb_valid`.
- ALU stream: 3 back-to-back non-memory ops, `wb_allowin`=1 → `wb_valid` on 3 consecutive cycles, `wb_result` = each `alu_result`, `in_ready` stays 1.
- Store byte: addr 0x1003, wdata 0x000000A5, num 00 → `data_addr`=0x1000, `data_wstrb`=4'b1000, `data_wdata`=0xA5A5A5A5, `data_wr`=1.
- Load half signed: addr 0x2002, rdata 0x8001_1234, signed=1 → `wb_result`=0xFFFF8001. Same with zero=1 → 0x00008001.
- Load byte zero: addr 0x2001, rdata 0x1122_F344 → `wb_result`=0x000000F3. `addr_ok` delayed 3 cycles → `data_req` held 4 cycles, `in_ready`=0 throughout.
- WB stall: `wb_allowin`=0 for 4 cycles in DONE → outputs unchanged, `in_ready`=0. Release in the same cycle as a new `in_valid` → new instruction accepted in that cycle.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Bundle of the EXE->MEM fields, data-SRAM bus and WB handshake for mem_access_stage.
// The stage itself uses the master view; the surrounding pipeline/SRAM use slave.
interface mem_access_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mem_pc;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_dram_waddr;
  logic [31:0] mem_dram_wdata;
  logic        mem_ref_we;
  logic [4:0]  mem_rd;
  logic        mem_dram_re;
  logic        mem_dram_we;
  logic [1:0]  mem_rdram_num;
  logic [1:0]  mem_wdram_num;
  logic        mem_rdram_need_signed_extend;
  logic        mem_rdram_need_zero_extend;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        wb_allowin;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [31:0] wb_pc;

  modport master (
    input  in_valid, mem_pc, mem_alu_result, mem_dram_waddr, mem_dram_wdata,
           mem_ref_we, mem_rd, mem_dram_re, mem_dram_we, mem_rdram_num,
           mem_wdram_num, mem_rdram_need_signed_extend, mem_rdram_need_zero_extend,
           data_addr_ok, data_data_ok, data_rdata, wb_allowin,
    output in_ready, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           wb_valid, wb_we, wb_rd, wb_result, wb_pc
  );

  modport slave (
    output in_valid, mem_pc, mem_alu_result, mem_dram_waddr, mem_dram_wdata,
           mem_ref_we, mem_rd, mem_dram_re, mem_dram_we, mem_rdram_num,
           mem_wdram_num, mem_rdram_need_signed_extend, mem_rdram_need_zero_extend,
           data_addr_ok, data_data_ok, data_rdata, wb_allowin,
    input  in_ready, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           wb_valid, wb_we, wb_rd, wb_result, wb_pc
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-SRAM req/resp handshake, store strobe/data alignment,
// load extraction and extension, valid/allowin hand-off to WB.
module mem_access_stage (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_stage_if.master   bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_q, alu_q, addr_q, wdata_q, ld_q;
  logic [4:0]  rd_q;
  logic        rf_we_q, re_q, we_q, sext_q;
  logic [1:0]  rnum_q, wnum_q;
  logic        accept, nx_mem, is_load;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;
  logic [3:0]  strb;
  logic [31:0] wdata_rep;

  assign bus.in_ready = (state == IDLE) | ((state == DONE) & bus.wb_allowin);
  assign accept       = bus.in_valid & bus.in_ready;
  assign nx_mem       = bus.mem_dram_re | bus.mem_dram_we;
  // re & we together is a store, so only a pure read takes the load path
  assign is_load      = re_q & ~we_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = nx_mem ? REQ : DONE;
      REQ:  if (bus.data_addr_ok) state_nx = WAIT;
      WAIT: if (bus.data_data_ok) state_nx = DONE;
      DONE: if (bus.wb_allowin) state_nx = accept ? (nx_mem ? REQ : DONE) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      alu_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rf_we_q <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      rnum_q  <= '0;
      wnum_q  <= '0;
      sext_q  <= 1'b0;
    end else if (accept) begin
      pc_q    <= bus.mem_pc;
      alu_q   <= bus.mem_alu_result;
      addr_q  <= bus.mem_dram_waddr;
      wdata_q <= bus.mem_dram_wdata;
      rd_q    <= bus.mem_rd;
      rf_we_q <= bus.mem_ref_we;
      re_q    <= bus.mem_dram_re;
      we_q    <= bus.mem_dram_we;
      rnum_q  <= bus.mem_rdram_num;
      wnum_q  <= bus.mem_wdram_num;
      sext_q  <= bus.mem_rdram_need_signed_extend;
    end
  end

  // responses outside WAIT are stale and never touch the result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         ld_q <= '0;
    else if (state == WAIT && bus.data_data_ok && is_load) ld_q <= ld_ext;
  end

  always_comb begin
    byte_sel = 8'(bus.data_rdata >> {addr_q[1:0], 3'b000});
    half_sel = addr_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    case (rnum_q)
      2'b00:   ld_ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   ld_ext = {{16{sext_q & half_sel[15]}}, half_sel};
      default: ld_ext = bus.data_rdata;
    endcase
  end

  always_comb begin
    case (wnum_q)
      2'b00: begin
        strb      = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strb      = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        strb      = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  assign bus.data_req   = (state == REQ);
  assign bus.data_wr    = we_q;
  assign bus.data_wstrb = we_q ? strb : 4'b0000;
  assign bus.data_addr  = {addr_q[31:2], 2'b00};
  assign bus.data_wdata = wdata_rep;

  assign bus.wb_valid  = (state == DONE);
  assign bus.wb_we     = rf_we_q;
  assign bus.wb_rd     = rd_q;
  assign bus.wb_pc     = pc_q;
  assign bus.wb_result = is_load ? ld_q : alu_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected WB results,
// a negedge monitor pops and compares on every wb_valid & wb_allowin.
module tb_mem_access_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   pop_cyc[$];

  mem_access_stage_if ifc();

  mem_access_stage dut (.clk(clk), .rst(rst), .bus(ifc.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && ifc.wb_valid && ifc.wb_allowin) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL wb_unexpected: got result %h with no expectation", ifc.wb_result);
      end else begin
        e = sb.pop_front();
        chk("wb_result", ifc.wb_result, e.res);
        chk("wb_pc", ifc.wb_pc, e.pc);
        chk("wb_rd_we", 32'({ifc.wb_rd, ifc.wb_we}), 32'({e.rd, e.we}));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Drives one instruction and holds in_valid until accepted; returns attempts used.
  task automatic send(input logic [31:0] pc, alu, addr, wd, input logic [4:0] rd,
                      input logic rfwe, re, we, input logic [1:0] rn, wn,
                      input logic sx, zx, input logic [31:0] exp_res, output int tries);
    bit ok = 0;
    ifc.mem_pc = pc; ifc.mem_alu_result = alu; ifc.mem_dram_waddr = addr;
    ifc.mem_dram_wdata = wd; ifc.mem_rd = rd; ifc.mem_ref_we = rfwe;
    ifc.mem_dram_re = re; ifc.mem_dram_we = we; ifc.mem_rdram_num = rn;
    ifc.mem_wdram_num = wn; ifc.mem_rdram_need_signed_extend = sx;
    ifc.mem_rdram_need_zero_extend = zx; ifc.in_valid = 1'b1;
    tries = 0;
    while (!ok && tries < 20) begin
      @(negedge clk);
      tries++;
      if (ifc.in_ready) begin
        ok = 1;
        sb.push_back('{pc, exp_res, rd, rfwe});
      end
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: got no in_ready expected accept within 20 cycles");
    end
  endtask

  // Called right after an accepted memory op; plays the SRAM side.
  task automatic serve(input int adly, input logic [31:0] rdata, exp_addr,
                       input logic exp_wr, input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    int req_cyc = 0;
    bit busy_bad = 0;
    for (int i = 0; i <= adly; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("data_addr", ifc.data_addr, exp_addr);
        chk("data_wr", 32'(ifc.data_wr), 32'(exp_wr));
        if (exp_wr) begin
          chk("data_wstrb", 32'(ifc.data_wstrb), 32'(exp_strb));
          chk("data_wdata", ifc.data_wdata, exp_wd);
        end
      end
      if (ifc.data_req) req_cyc++;
      if (ifc.in_ready) busy_bad = 1;
      if (i == adly) ifc.data_addr_ok = 1'b1;
      @(posedge clk); #1;
      ifc.data_addr_ok = 1'b0;
    end
    @(negedge clk);
    if (ifc.data_req || ifc.in_ready) busy_bad = 1;
    ifc.data_rdata = rdata;
    ifc.data_data_ok = 1'b1;
    @(posedge clk); #1;
    ifc.data_data_ok = 1'b0;
    chk("req_cycles", 32'(req_cyc), 32'(adly + 1));
    chk("busy_in_ready_req", 32'(busy_bad), 0);
  endtask

  initial begin
    int t;
    bit stall_bad;
    ifc.in_valid = 0; ifc.mem_pc = 0; ifc.mem_alu_result = 0; ifc.mem_dram_waddr = 0;
    ifc.mem_dram_wdata = 0; ifc.mem_ref_we = 0; ifc.mem_rd = 0; ifc.mem_dram_re = 0;
    ifc.mem_dram_we = 0; ifc.mem_rdram_num = 0; ifc.mem_wdram_num = 0;
    ifc.mem_rdram_need_signed_extend = 0; ifc.mem_rdram_need_zero_extend = 0;
    ifc.data_addr_ok = 0; ifc.data_data_ok = 0; ifc.data_rdata = 0; ifc.wb_allowin = 1;

    @(negedge clk);
    chk("rst_in_ready", 32'(ifc.in_ready), 1);
    chk("rst_wb_valid", 32'(ifc.wb_valid), 0);
    chk("rst_data_req", 32'(ifc.data_req), 0);
    chk("rst_outputs", ifc.wb_result | ifc.wb_pc | ifc.data_addr | ifc.data_wdata, 0);
    chk("rst_strb", 32'({ifc.data_wstrb, ifc.data_wr, ifc.wb_we, ifc.wb_rd}), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // ALU stream: three back-to-back results on consecutive cycles
    pop_cyc.delete();
    send(32'h0, 32'h1111_0001, 0, 0, 5'd1, 1, 0, 0, 0, 0, 0, 0, 32'h1111_0001, t);
    send(32'h4, 32'h2222_0002, 0, 0, 5'd2, 1, 0, 0, 0, 0, 0, 0, 32'h2222_0002, t);
    send(32'h8, 32'h3333_0003, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 0, 32'h3333_0003, t);
    chk("alu_stream_accept", 32'(t), 1);
    repeat (2) @(posedge clk); #1;
    chk("alu_stream_count", 32'(pop_cyc.size()), 3);
    if (pop_cyc.size() == 3) begin
      chk("alu_stream_b2b_1", 32'(pop_cyc[1] - pop_cyc[0]), 1);
      chk("alu_stream_b2b_2", 32'(pop_cyc[2] - pop_cyc[1]), 1);
    end

    // Stores: byte, half, word (size 11 behaves as word)
    send(32'h100, 32'h1003, 32'h1003, 32'h0000_00A5, 5'd0, 0, 0, 1, 0, 2'b00, 0, 0, 32'h1003, t);
    serve(0, 0, 32'h1000, 1, 4'b1000, 32'hA5A5_A5A5);
    send(32'h104, 32'h1006, 32'h1006, 32'h0000_BEEF, 5'd0, 0, 0, 1, 0, 2'b01, 0, 0, 32'h1006, t);
    serve(0, 0, 32'h1004, 1, 4'b1100, 32'hBEEF_BEEF);
    send(32'h108, 32'h1009, 32'h1009, 32'h1234_5678, 5'd0, 0, 0, 1, 0, 2'b11, 0, 0, 32'h1009, t);
    serve(1, 0, 32'h1008, 1, 4'b1111, 32'h1234_5678);

    // Loads: sign/zero extension, sub-word select, delayed addr_ok
    send(32'h200, 32'h2002, 32'h2002, 0, 5'd5, 1, 1, 0, 2'b01, 0, 1, 0, 32'hFFFF_8001, t);
    serve(0, 32'h8001_1234, 32'h2000, 0, 0, 0);
    send(32'h204, 32'h2002, 32'h2002, 0, 5'd6, 1, 1, 0, 2'b01, 0, 0, 1, 32'h0000_8001, t);
    serve(0, 32'h8001_1234, 32'h2000, 0, 0, 0);
    send(32'h208, 32'h2001, 32'h2001, 0, 5'd7, 1, 1, 0, 2'b00, 0, 0, 1, 32'h0000_00F3, t);
    serve(3, 32'h1122_F344, 32'h2000, 0, 0, 0);
    send(32'h20C, 32'h2003, 32'h2003, 0, 5'd8, 1, 1, 0, 2'b00, 0, 1, 0, 32'hFFFF_FF9A, t);
    serve(0, 32'h9A00_0000, 32'h2000, 0, 0, 0);
    send(32'h210, 32'h2006, 32'h2006, 0, 5'd9, 1, 1, 0, 2'b10, 0, 1, 0, 32'hCAFE_BABE, t);
    serve(0, 32'hCAFE_BABE, 32'h2004, 0, 0, 0);

    // re & we together is a store: result is the ALU value, not the response
    send(32'h300, 32'h77, 32'h3000, 32'h55, 5'd10, 1, 1, 1, 2'b10, 2'b10, 0, 0, 32'h77, t);
    serve(0, 32'hDEAD_BEEF, 32'h3000, 1, 4'b1111, 32'h55);
    @(posedge clk); #1;

    // WB stall: outputs hold, in_ready low; release together with a new in_valid
    ifc.wb_allowin = 1'b0;
    send(32'h500, 32'hABCD_0001, 0, 0, 5'd11, 1, 0, 0, 0, 0, 0, 0, 32'hABCD_0001, t);
    stall_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!ifc.wb_valid || ifc.in_ready || ifc.wb_result !== 32'hABCD_0001 ||
          ifc.wb_pc !== 32'h500 || ifc.wb_rd !== 5'd11) stall_bad = 1;
      @(posedge clk); #1;
    end
    chk("stall_hold", 32'(stall_bad), 0);
    ifc.wb_allowin = 1'b1;
    send(32'h504, 32'h22, 0, 0, 5'd12, 1, 0, 0, 0, 0, 0, 0, 32'h22, t);
    chk("stall_release_accept", 32'(t), 1);

    // Reset mid-WAIT: request and result vanish, a late data_ok is ignored
    send(32'h600, 32'h2000, 32'h2000, 0, 5'd13, 1, 1, 0, 2'b10, 0, 0, 0, 32'h0, t);
    @(negedge clk);
    ifc.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    ifc.data_addr_ok = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rstwait_data_req", 32'(ifc.data_req), 0);
    chk("rstwait_wb_valid", 32'(ifc.wb_valid), 0);
    chk("rstwait_in_ready", 32'(ifc.in_ready), 1);
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    ifc.data_rdata = 32'h1234_5678;
    ifc.data_data_ok = 1'b1;
    @(posedge clk); #1 ifc.data_data_ok = 1'b0;
    @(negedge clk);
    chk("stale_data_ok", 32'(ifc.wb_valid), 0);

    // Reset mid-REQ: data_req drops at once; a stray addr_ok afterwards is ignored
    @(posedge clk); #1;
    send(32'h700, 32'h2000, 32'h2000, 0, 5'd14, 1, 1, 0, 2'b10, 0, 0, 0, 32'h0, t);
    #2 rst = 1'b0;
    #1 chk("rstreq_data_req", 32'(ifc.data_req), 0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    ifc.data_addr_ok = 1'b1;
    @(posedge clk); #1 ifc.data_addr_ok = 1'b0;
    @(negedge clk);
    chk("stray_addr_ok", 32'({ifc.data_req, ifc.in_ready, ifc.wb_valid}), 32'b010);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
